// File: rtl/ddr2_port_arbiter.sv
// Burst scheduler between the user write/read FIFOs and the DDR2 controller local port.
// Whole bursts are granted round-robin; write and read addresses wrap inside their own windows.
module ddr2_port_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int BURST_W    = 7,
    parameter int USEDW_W    = 10,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_done,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [ADDR_W-1:0]  wr_minaddr,
    input  logic [ADDR_W-1:0]  wr_maxaddr,
    input  logic [ADDR_W-1:0]  rd_minaddr,
    input  logic [ADDR_W-1:0]  rd_maxaddr,
    input  logic               wr_load,
    input  logic               rd_load,
    input  logic               rd_en,
    input  logic [USEDW_W-1:0] wfifo_usedw,
    input  logic [USEDW_W-1:0] rfifo_usedw,
    output logic               wfifo_rdreq,
    output logic               rfifo_wrreq,
    input  logic               local_ready,
    input  logic               local_rdata_valid,
    output logic [ADDR_W-1:0]  local_address,
    output logic [BURST_W-1:0] local_size,
    output logic               local_write_req,
    output logic               local_read_req,
    output logic               local_burstbegin,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, RD_WAIT} state_t;
    typedef enum logic {GRANT_WRITE, GRANT_READ} side_t;

    state_t             state, state_nxt;
    side_t              last_grant, last_grant_nxt;
    logic [ADDR_W-1:0]  wr_addr, wr_addr_nxt, rd_addr, rd_addr_nxt, address_nxt;
    logic [ADDR_W-1:0]  wr_base, rd_base;
    logic [BURST_W-1:0] size_nxt, beat_cnt, beat_cnt_nxt;
    logic               write_req_nxt, read_req_nxt, burstbegin_nxt;
    logic               wr_load_pend, wr_load_pend_nxt, rd_load_pend, rd_load_pend_nxt;
    logic [USEDW_W:0]   burst_ext, rd_room;
    logic               wr_pend, rd_pend, accept, last_beat;

    // One extra bit so a completely empty read FIFO (room == FIFO_DEPTH) still compares correctly.
    assign burst_ext = (USEDW_W+1)'(burst_len);
    assign rd_room   = (USEDW_W+1)'(FIFO_DEPTH) - {1'b0, rfifo_usedw};
    assign wr_pend   = init_done && (burst_len != '0) && ({1'b0, wfifo_usedw} >= burst_ext);
    assign rd_pend   = init_done && rd_en && (burst_len != '0) && (rd_room >= burst_ext);

    assign accept      = (state == WR_BURST) && local_write_req && local_ready;
    assign last_beat   = (beat_cnt == local_size - BURST_W'(1));
    assign wfifo_rdreq = accept;
    assign rfifo_wrreq = (state == RD_WAIT) && local_rdata_valid;
    assign wr_base     = wr_load ? wr_minaddr : wr_addr;
    assign rd_base     = rd_load ? rd_minaddr : rd_addr;

    function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] addr,
                                                  input logic [BURST_W-1:0] size,
                                                  input logic [ADDR_W-1:0] minaddr,
                                                  input logic [ADDR_W-1:0] maxaddr);
        logic [ADDR_W:0] nxt;
        nxt = {1'b0, addr} + (ADDR_W+1)'(size);
        return (nxt >= {1'b0, maxaddr}) ? minaddr : nxt[ADDR_W-1:0];
    endfunction

    always_comb begin
        state_nxt        = state;
        last_grant_nxt   = last_grant;
        wr_addr_nxt      = wr_addr;
        rd_addr_nxt      = rd_addr;
        address_nxt      = local_address;
        size_nxt         = local_size;
        beat_cnt_nxt     = beat_cnt;
        write_req_nxt    = local_write_req;
        read_req_nxt     = local_read_req;
        burstbegin_nxt   = local_burstbegin;
        wr_load_pend_nxt = wr_load_pend;
        rd_load_pend_nxt = rd_load_pend;
        unique case (state)
            IDLE: begin
                wr_addr_nxt      = wr_base;
                rd_addr_nxt      = rd_base;
                wr_load_pend_nxt = 1'b0;
                rd_load_pend_nxt = 1'b0;
                beat_cnt_nxt     = '0;
                if (wr_pend && (!rd_pend || last_grant == GRANT_READ)) begin
                    state_nxt      = WR_BURST;
                    address_nxt    = wr_base;
                    size_nxt       = burst_len;
                    write_req_nxt  = 1'b1;
                    burstbegin_nxt = 1'b1;
                end else if (rd_pend) begin
                    state_nxt      = RD_CMD;
                    address_nxt    = rd_base;
                    size_nxt       = burst_len;
                    read_req_nxt   = 1'b1;
                    burstbegin_nxt = 1'b1;
                end
            end
            WR_BURST: begin
                rd_addr_nxt = rd_base;
                if (wr_load) wr_load_pend_nxt = 1'b1;
                if (accept) begin
                    beat_cnt_nxt   = beat_cnt + BURST_W'(1);
                    burstbegin_nxt = 1'b0;
                    if (last_beat) begin
                        // A load seen during the burst overrides the normal advance.
                        wr_addr_nxt      = (wr_load_pend || wr_load) ? wr_minaddr
                                         : advance(wr_addr, local_size, wr_minaddr, wr_maxaddr);
                        wr_load_pend_nxt = 1'b0;
                        write_req_nxt    = 1'b0;
                        last_grant_nxt   = GRANT_WRITE;
                        state_nxt        = IDLE;
                    end
                end
            end
            RD_CMD: begin
                wr_addr_nxt = wr_base;
                if (rd_load) rd_load_pend_nxt = 1'b1;
                if (local_ready) begin
                    rd_addr_nxt    = advance(rd_addr, local_size, rd_minaddr, rd_maxaddr);
                    read_req_nxt   = 1'b0;
                    burstbegin_nxt = 1'b0;
                    last_grant_nxt = GRANT_READ;
                    state_nxt      = RD_WAIT;
                end
            end
            RD_WAIT: begin
                wr_addr_nxt = wr_base;
                if (rd_load) rd_load_pend_nxt = 1'b1;
                if (local_rdata_valid) begin
                    beat_cnt_nxt = beat_cnt + BURST_W'(1);
                    if (last_beat) begin
                        if (rd_load_pend || rd_load) rd_addr_nxt = rd_minaddr;
                        rd_load_pend_nxt = 1'b0;
                        state_nxt        = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= GRANT_READ;
            wr_addr          <= wr_minaddr;
            rd_addr          <= rd_minaddr;
            local_address    <= '0;
            local_size       <= '0;
            beat_cnt         <= '0;
            local_write_req  <= 1'b0;
            local_read_req   <= 1'b0;
            local_burstbegin <= 1'b0;
            wr_load_pend     <= 1'b0;
            rd_load_pend     <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_nxt;
            last_grant       <= last_grant_nxt;
            wr_addr          <= wr_addr_nxt;
            rd_addr          <= rd_addr_nxt;
            local_address    <= address_nxt;
            local_size       <= size_nxt;
            beat_cnt         <= beat_cnt_nxt;
            local_write_req  <= write_req_nxt;
            local_read_req   <= read_req_nxt;
            local_burstbegin <= burstbegin_nxt;
            wr_load_pend     <= wr_load_pend_nxt;
            rd_load_pend     <= rd_load_pend_nxt;
            busy             <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Bench for ddr2_port_arbiter: grant-decision vector table, then a burst scoreboard that
// checks grant order, addresses, sizes and beat counts against a small address model.
module tb_ddr2_port_arbiter;

    logic        clk, rst, init_done, wr_load, rd_load, rd_en;
    logic [6:0]  burst_len;
    logic [23:0] wr_minaddr, wr_maxaddr, rd_minaddr, rd_maxaddr;
    logic [9:0]  wfifo_usedw, rfifo_usedw;
    logic        wfifo_rdreq, rfifo_wrreq, local_ready, local_rdata_valid;
    logic [23:0] local_address;
    logic [6:0]  local_size;
    logic        local_write_req, local_read_req, local_burstbegin, busy;

    typedef struct {
        string name;
        bit    init;
        bit    rden;
        int    blen;
        int    wused;
        int    rused;
        bit    exp_wr;
        bit    exp_rd;
    } vec_t;

    typedef struct {
        bit is_write;
        int addr;
        int beats;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    exp_t cur;
    int   checks = 0, failures = 0;
    int   wfifo_level, rfifo_level, rd_resp_cnt, ready_mode;
    int   mon_beats;
    bit   mon_active, mon_en;

    assign wfifo_usedw = 10'(wfifo_level);
    assign rfifo_usedw = 10'(rfifo_level);

    ddr2_port_arbiter dut (
        .clk(clk), .rst(rst), .init_done(init_done), .burst_len(burst_len),
        .wr_minaddr(wr_minaddr), .wr_maxaddr(wr_maxaddr),
        .rd_minaddr(rd_minaddr), .rd_maxaddr(rd_maxaddr),
        .wr_load(wr_load), .rd_load(rd_load), .rd_en(rd_en),
        .wfifo_usedw(wfifo_usedw), .rfifo_usedw(rfifo_usedw),
        .wfifo_rdreq(wfifo_rdreq), .rfifo_wrreq(rfifo_wrreq),
        .local_ready(local_ready), .local_rdata_valid(local_rdata_valid),
        .local_address(local_address), .local_size(local_size),
        .local_write_req(local_write_req), .local_read_req(local_read_req),
        .local_burstbegin(local_burstbegin), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    function automatic int adv(input int a, input int sz, input int mn, input int mx);
        return (a + sz >= mx) ? mn : a + sz;
    endfunction

    task automatic addVec(input string n, input bit i, input bit r, input int b, input int w,
                          input int u, input bit ew, input bit er);
        vec_t v;
        v.name = n; v.init = i; v.rden = r; v.blen = b; v.wused = w; v.rused = u;
        v.exp_wr = ew; v.exp_rd = er;
        vecs.push_back(v);
    endtask

    task automatic pushExp(input bit w, input int a, input int n);
        exp_t e;
        e.is_write = w; e.addr = a; e.beats = n;
        sb_q.push_back(e);
    endtask

    // Controller model: ready pattern plus read data returned after each accepted read command.
    initial begin
        local_ready = 1'b0;
        local_rdata_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       local_ready = 1'b1;
                1:       local_ready = ~local_ready;
                default: local_ready = 1'b0;
            endcase
            if (rd_resp_cnt > 0 && (ready_mode != 1 || local_ready)) begin
                local_rdata_valid = 1'b1;
                rd_resp_cnt--;
            end else begin
                local_rdata_valid = 1'b0;
            end
        end
    end

    // Monitor: pops the expected burst at each grant and counts FIFO beats until busy drops.
    initial begin
        mon_active = 0;
        mon_beats = 0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                mon_active = 0;
            end else begin
                if (local_read_req && local_ready) rd_resp_cnt += int'(local_size);
                if (!mon_active && (local_write_req || local_read_req)) begin
                    mon_active = 1;
                    mon_beats = 0;
                    if (sb_q.size() == 0) begin
                        checkOutput("unexpected_grant", {30'd0, local_write_req, local_read_req}, 0);
                        cur.is_write = local_write_req; cur.addr = -1; cur.beats = -1;
                    end else begin
                        cur = sb_q.pop_front();
                        checkOutput("grant_kind", local_write_req, cur.is_write);
                        checkOutput("grant_addr", local_address, 32'(cur.addr));
                        checkOutput("grant_size", local_size, 32'(cur.beats));
                        checkOutput("grant_begin", local_burstbegin, 1);
                    end
                end
                if (mon_active) begin
                    checkOutput("addr_hold", local_address, 32'(cur.addr));
                    if (wfifo_rdreq) begin
                        checkOutput("burstbegin_beat", local_burstbegin, (mon_beats == 0));
                        mon_beats++;
                        wfifo_level--;
                    end
                    if (rfifo_wrreq) begin
                        mon_beats++;
                        rfifo_level++;
                    end
                    if (!busy) begin
                        checkOutput("burst_beats", mon_beats, cur.beats);
                        mon_active = 0;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        rst = 1; init_done = v.init; rd_en = v.rden; burst_len = 7'(v.blen);
        wfifo_level = v.wused; rfifo_level = v.rused;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        checkOutput({v.name, "_wr"}, local_write_req, v.exp_wr);
        checkOutput({v.name, "_rd"}, local_read_req, v.exp_rd);
        checkOutput({v.name, "_size"}, local_size, (v.exp_wr || v.exp_rd) ? v.blen : 0);
    endtask

    task automatic doReset();
        rst = 1;
        rd_resp_cnt = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic waitDone(input string name, input int max_cycles);
        int n = 0;
        while ((sb_q.size() != 0 || mon_active || busy) && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, "_done"}, (n < max_cycles), 1);
        repeat (4) begin @(posedge clk); #1; end
        checkOutput({name, "_quiet"}, busy, 0);
    endtask

    task automatic waitBeats(input string name, input int target);
        int n = 0;
        while (!(mon_active && mon_beats >= target) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, (n < 300), 1);
    endtask

    int wm, rm, cnt, n;

    initial begin
        rst = 1; init_done = 0; burst_len = 64; wr_load = 0; rd_load = 0; rd_en = 0;
        wr_minaddr = 0; wr_maxaddr = 1024; rd_minaddr = 24'h1000; rd_maxaddr = 24'h1400;
        wfifo_level = 0; rfifo_level = 0; rd_resp_cnt = 0; ready_mode = 2; mon_en = 0;

        addVec("no_init",       0, 1, 64, 100,    0, 0, 0);
        addVec("wr_exact",      1, 0, 64,  64,    0, 1, 0);
        addVec("wr_short",      1, 0, 64,  63,    0, 0, 0);
        addVec("blen_zero",     1, 1,  0, 100,    0, 0, 0);
        addVec("rd_only",       1, 1, 64,   0,    0, 0, 1);
        addVec("rd_room_exact", 1, 1, 64,   0,  960, 0, 1);
        addVec("rd_room_short", 1, 1, 64,   0,  961, 0, 0);
        addVec("rd_disabled",   1, 0, 64,   0,    0, 0, 0);
        addVec("tie_write",     1, 1, 64,  64,    0, 1, 0);
        addVec("tie_burst1",    1, 1,  1,   1, 1023, 1, 0);
        addVec("rd_room_one",   1, 1,  1,   0, 1023, 0, 1);
        addVec("rd_blen100",    1, 1, 100, 99,  924, 0, 1);

        repeat (2) begin @(posedge clk); #1; end
        checkOutput("reset_ctrl", {26'd0, local_write_req, local_read_req, local_burstbegin,
                                   busy, wfifo_rdreq, rfifo_wrreq}, 0);
        checkOutput("reset_addr", local_address, 0);
        checkOutput("reset_size", local_size, 0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Calibration gate, then a full 64-beat write and the advanced address.
        mon_en = 1; ready_mode = 0; init_done = 0; rd_en = 0; burst_len = 64; wfifo_level = 100;
        doReset();
        repeat (5) begin @(posedge clk); #1; end
        checkOutput("no_req_before_init", {local_write_req, busy}, 0);
        pushExp(1, 0, 64);
        init_done = 1;
        n = 0;
        while (!local_write_req && n < 5) begin @(posedge clk); #1; n++; end
        checkOutput("init_to_req", (n >= 1 && n <= 2), 1);
        waitDone("first_write", 500);
        pushExp(1, 64, 64);
        wfifo_level += 64;
        waitDone("second_write", 500);

        // Both sides pending: alternate W,R,W,R.
        wfifo_level = 128; rfifo_level = 1024 - 128 - 1; rd_en = 1;
        pushExp(1, 0, 64); pushExp(0, 24'h1000, 64); pushExp(1, 64, 64); pushExp(0, 24'h1040, 64);
        doReset();
        waitDone("round_robin", 2000);

        // Address wrap in both windows over two refill phases.
        wfifo_level = 0; rfifo_level = 1023;
        doReset();
        wm = 0; rm = 24'h1000;
        for (int p = 0; p < 2; p++) begin
            cnt = (p == 0) ? 10 : 7;
            for (int i = 0; i < cnt; i++) begin
                pushExp(1, wm, 64); pushExp(0, rm, 64);
                wm = adv(wm, 64, 0, 1024);
                rm = adv(rm, 64, 24'h1000, 24'h1400);
            end
            rfifo_level = 1023 - 64 * cnt;
            wfifo_level = 64 * cnt;
            waitDone("wrap", 5000);
        end
        checkOutput("wrap_wr_model", wm, 64);
        checkOutput("wrap_rd_model", rm, 24'h1040);

        // Stalled write, with burst_len and init_done changed mid-burst.
        rd_en = 0; ready_mode = 1; wfifo_level = 200; burst_len = 64;
        pushExp(1, 0, 64);
        doReset();
        waitBeats("stall_started", 1);
        burst_len = 32;
        repeat (10) begin @(posedge clk); #1; end
        init_done = 0;
        waitDone("stall_write", 500);
        init_done = 1; burst_len = 64; wfifo_level = 64;
        pushExp(1, 64, 64);
        waitDone("stall_next", 500);

        // Reset mid-burst, then load mid-burst.
        ready_mode = 0; wr_minaddr = 24'h100; wr_maxaddr = 24'h1000; wfifo_level = 64;
        pushExp(1, 24'h100, 64);
        doReset();
        waitDone("win_first", 500);
        wfifo_level = 64;
        pushExp(1, 24'h140, 64);
        waitBeats("reach_beat20", 20);
        rst = 1;
        @(posedge clk); #1;
        checkOutput("midrst_ctrl", {26'd0, local_write_req, local_read_req, local_burstbegin,
                                    busy, wfifo_rdreq, rfifo_wrreq}, 0);
        checkOutput("midrst_addr", local_address, 0);
        rd_resp_cnt = 0; wfifo_level = 64;
        pushExp(1, 24'h100, 64);
        rst = 0;
        waitDone("after_rst", 500);
        wfifo_level = 128;
        pushExp(1, 24'h140, 64); pushExp(1, 24'h100, 64);
        waitBeats("load_started", 10);
        wr_load = 1;
        @(posedge clk); #1;
        wr_load = 0;
        waitDone("wr_load", 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
